// File: rtl/parity_checker_serial.sv
// Serial frame receiver: DATA_W data bits LSB-first, then one parity bit, checked against
// an even/odd scheme latched at frame start. Optional error counter: PARITY_CHECKER_ERR_CNT_EN.
module parity_checker_serial #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              odd_mode,
`ifdef PARITY_CHECKER_ERR_CNT_EN
  input  logic              err_clr,
  output logic [7:0]        err_count,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StPar
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              odd_q;
  logic              frame_err;
  logic              par_accept;

  // Error when the received parity bit differs from XOR(data) folded with the scheme bit.
  assign frame_err  = bit_in ^ (^shift_q) ^ odd_q;
  assign par_accept = (state_q == StPar) && bit_valid;
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      odd_q      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StData;
            cnt_q   <= '0;
            odd_q   <= odd_mode;
          end
        end
        StData: begin
          if (bit_valid) begin
            shift_q <= {bit_in, shift_q[DATA_W-1:1]};
            if (cnt_q == CntW'(DATA_W - 1)) begin
              state_q <= StPar;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StPar: begin
          if (bit_valid) begin
            data_out   <= shift_q;
            parity_err <= frame_err;
            data_valid <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PARITY_CHECKER_ERR_CNT_EN
  // Clear takes priority over a coincident increment; count saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (err_clr) begin
      err_count <= 8'd0;
    end else if (par_accept && frame_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_checker_serial.sv
// Directed bench for parity_checker_serial; completed frames are scored against a queue of
// expected {data, error, due cycle} entries pushed as each parity bit is driven.
module tb_parity_checker_serial;

  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              bit_in = 1'b0;
  logic              bit_valid = 1'b0;
  logic              odd_mode = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              busy;
`ifdef PARITY_CHECKER_ERR_CNT_EN
  logic              err_clr = 1'b0;
  logic [7:0]        err_count;
`endif

  parity_checker_serial #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .odd_mode   (odd_mode),
`ifdef PARITY_CHECKER_ERR_CNT_EN
    .err_clr    (err_clr),
    .err_count  (err_count),
`endif
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              e;
    int                due;
  } exp_t;

  exp_t sb[$];
  int   ncmp    = 0;
  int   nerr    = 0;
  int   cyc     = 0;
  int   npulse  = 0;
  int   nframes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard side: every data_valid pulse must match the oldest outstanding frame.
  always @(posedge clk) begin
    #1;
    if (data_valid) begin
      npulse++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t x;
        x = sb.pop_front();
        check("data_out", 32'(data_out), 32'(x.d));
        check("parity_err", 32'(parity_err), 32'(x.e));
        check("dv_latency", 32'(cyc), 32'(x.due));
      end
    end
  end

  task automatic drive(input logic s, input logic v, input logic b);
    @(negedge clk);
    start     = s;
    bit_valid = v;
    bit_in    = b;
`ifdef PARITY_CHECKER_ERR_CNT_EN
    err_clr   = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic par, input logic odd,
                            input int gap, input bit mid_start, input bit clr);
    exp_t x;
    // bit_valid is asserted with a wrong bit during the start cycle; it must be ignored.
    drive(1'b1, 1'b1, ~d[0]);
    odd_mode = odd;
    for (int i = 0; i < int'(DATA_W); i++) begin
      repeat (gap) drive(1'b0, 1'b0, 1'($urandom));
      drive(1'(mid_start && (i == 3)), 1'b1, d[i]);
      if (i == 0) odd_mode = ~odd;
    end
    repeat (gap) drive(1'b0, 1'b0, 1'($urandom));
    drive(1'b0, 1'b1, par);
`ifdef PARITY_CHECKER_ERR_CNT_EN
    err_clr = clr;
`else
    if (clr) $display("note: err_clr ignored without counter");
`endif
    x.d   = d;
    x.e   = par ^ (^d) ^ odd;
    x.due = cyc + 1;
    sb.push_back(x);
    nframes++;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
`ifdef PARITY_CHECKER_ERR_CNT_EN
    check("rst_cnt", 32'(err_count), 32'd0);
`endif
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Basic even frame, then hold of outputs
    send_frame(8'h01, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("busy_after", 32'(busy), 32'd0);
    idle(3);
    check("hold_data", 32'(data_out), 32'h01);
    check("hold_perr", 32'(parity_err), 32'd0);

    // Even 0xAA with both parity values, back-to-back (start coincident with data_valid)
    send_frame(8'hAA, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(2);

    // Odd mode, without and with gaps
    send_frame(8'hFF, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    idle(2);
    check("hold_perr_odd", 32'(parity_err), 32'd1);

    // Start strobed mid-frame must not disturb it; busy checked inside the frame
    drive(1'b1, 1'b0, 1'b0);
    odd_mode = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    check("busy_mid", 32'(busy), 32'd1);
    for (int i = 1; i < int'(DATA_W); i++) drive(1'(i == 4), 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    begin
      exp_t x;
      x.d = 8'h01; x.e = 1'b0; x.due = cyc + 1;
      sb.push_back(x);
      nframes++;
    end
    send_frame(8'h5C, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    idle(3);

    // Reset mid-frame: partial frame discarded, no pulse
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", 32'(data_out), 32'd0);
    idle(2);
    rst_n = 1'b1;
    send_frame(8'h03, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    check("post_abort_data", 32'(data_out), 32'h03);

    // Random frames
    for (int k = 0; k < 12; k++) begin
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                 1'($urandom), 1'b0);
      if (k % 3 == 2) idle(1);
    end
    idle(3);

`ifdef PARITY_CHECKER_ERR_CNT_EN
    drive(1'b0, 1'b0, 1'b0);
    err_clr = 1'b1;
    idle(1);
    check("cnt_clr", 32'(err_count), 32'd0);
    send_frame(8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'h07, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(1);
    check("cnt_two", 32'(err_count), 32'd1 + 32'd1);
    for (int k = 0; k < 300; k++) send_frame(8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(1);
    check("cnt_sat", 32'(err_count), 32'd255);
    drive(1'b0, 1'b0, 1'b0);
    err_clr = 1'b1;
    idle(1);
    send_frame(8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'h10, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(1);
    check("cnt_clr_wins", 32'(err_count), 32'd0);
    idle(2);
`endif

    idle(4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("pulse_count", 32'(npulse), 32'(nframes));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/parity_checker_serial.md
PARITY_CHECKER_SERIAL -- requirements
Module: parity_checker_serial

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  frame-start strobe, sampled only in IDLE.
REQ-005 SHALL have port bit_in  input  1  serial data/parity bit.
REQ-006 SHALL have port bit_valid  input  1  bit_in qualifier, one bit accepted per cycle high.
REQ-007 SHALL have port odd_mode  input  1  0 = even scheme (parity bit = XOR of data), 1 = odd scheme (parity bit = XNOR of data); sampled at start.
REQ-008 SHALL have port data_out  output  DATA_W  last received data word.
REQ-009 SHALL have port data_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port parity_err  output  1  error flag of last completed frame.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, DATA, PAR.
REQ-013 IDLE -> DATA on start=1; bit counter cleared, odd_mode latched; bit_valid in the same cycle SHALL be ignored.
REQ-014 DATA: each cycle with bit_valid=1 SHALL shift bit_in in LSB-first; after DATA_W accepted bits -> PAR.
REQ-015 Cycles with bit_valid=0 SHALL hold all state (arbitrary gaps allowed).
REQ-016 PAR: on bit_valid=1, the module SHALL compute the error as (bit_in != (XOR(data) XOR latched odd_mode)), then -> IDLE.
REQ-017 data_out, parity_err and data_valid=1 SHALL be registered and appear the cycle after the parity bit is accepted (latency 1).
REQ-018 data_valid SHALL be high exactly one cycle per frame.
REQ-019 data_out and parity_err SHALL hold their values until the next frame completes.
REQ-020 start while busy=1 SHALL be ignored, with no effect on the current frame.
REQ-021 A new start SHALL be accepted in the same cycle that data_valid is high.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, bit counter 0, shift register 0, data_out 0, data_valid 0, parity_err 0, busy 0, and err_count 0 when present.
REQ-023 Reset mid-frame SHALL discard the partial frame, with no data_valid pulse and no counter change.

Configuration
REQ-024 Macro PARITY_CHECKER_ERR_CNT_EN defined: the module SHALL add input err_clr (1 bit) and output err_count (8 bits), counting completed frames with parity_err=1.
REQ-025 err_count SHALL update in the data_valid cycle and SHALL saturate at 255.
REQ-026 err_clr=1 SHALL zero err_count on the next edge; on coincidence with an increment, clear wins and the result is 0.
REQ-027 Macro undefined: err_clr and err_count SHALL be absent, with no counter logic; all other behaviour identical.

Verification
REQ-028 Even mode, start, bits 1,0,0,0,0,0,0,0 then parity 1 -> data_out=0x01, parity_err=0, data_valid for one cycle, one cycle after the parity bit.
REQ-029 Even mode, data 0xAA, parity bit 1 -> data_out=0xAA, parity_err=1; parity bit 0 -> parity_err=0.
REQ-030 Odd mode, data 0xFF with parity 1 -> parity_err=0; data 0x00 with parity 0 -> parity_err=1; bit_valid gaps of 3 cycles between bits -> same results.
REQ-031 Reset after 3 data bits, then frame 0x03 with even parity 0 -> busy=0 after reset, no pulse from the aborted frame, next frame data_out=0x03, parity_err=0.
REQ-032 start pulsed mid-frame, plus start coincident with data_valid -> first ignored with frame intact; second begins a new frame correctly.
REQ-033 With PARITY_CHECKER_ERR_CNT_EN: 300 error frames -> err_count=255; err_clr coincident with an error frame -> err_count=0.
